// File: rtl/banco_registro_param.sv
// Register bank: one write port, two registered read ports with write-first bypass, pending bits.
// Optional REG_ZERO_EN hardwires register 0 to zero.
module banco_registro_param #(
  parameter int BITS_PALAVRA  = 16,
  parameter int END_REGISTROS = 3,
  parameter int NUM_REGISTROS = 2**END_REGISTROS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     hab_escrita,
  input  logic [END_REGISTROS-1:0] sel_e,
  input  logic [BITS_PALAVRA-1:0]  e,
  input  logic                     hab_leitura,
  input  logic [END_REGISTROS-1:0] sel_a,
  input  logic [END_REGISTROS-1:0] sel_b,
  input  logic                     reserva,
  input  logic [END_REGISTROS-1:0] sel_r,
  output logic [BITS_PALAVRA-1:0]  a,
  output logic [BITS_PALAVRA-1:0]  b,
  output logic                     pend_a,
  output logic                     pend_b,
  output logic [END_REGISTROS:0]   n_pendentes
);

  localparam int AW = END_REGISTROS;
  localparam int DW = BITS_PALAVRA;
`ifdef REG_ZERO_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  typedef logic [AW-1:0] addr_t;

  logic [DW-1:0]            reg_q [NUM_REGISTROS];
  logic [DW-1:0]            reg_d [NUM_REGISTROS];
  logic [NUM_REGISTROS-1:0] pend_q, pend_d;
  logic [DW-1:0]            a_q, a_d, b_q, b_d;
  logic                     pa_q, pa_d, pb_q, pb_d;
  logic [AW:0]              cnt_q, cnt_d;

  logic we, rs, pe, pr, inc, dec;

  // Addresses past the bank (or r0 when hardwired) behave as absent
  function automatic logic ok(input addr_t s);
    return (int'(s) >= FIRST) && (int'(s) < NUM_REGISTROS);
  endfunction

  always_comb begin
    we     = hab_escrita && ok(sel_e);
    rs     = reserva && ok(sel_r);
    reg_d  = reg_q;
    pend_d = pend_q;
    pe     = 1'b0;
    pr     = 1'b0;
    a_d    = '0;
    b_d    = '0;
    pa_d   = 1'b0;
    pb_d   = 1'b0;
    for (int i = 0; i < NUM_REGISTROS; i++) begin
      if (addr_t'(i) == sel_e) pe = pend_q[i];
      if (addr_t'(i) == sel_r) pr = pend_q[i];
      if (we && addr_t'(i) == sel_e) begin
        reg_d[i]  = e;
        pend_d[i] = 1'b0;
      end
      // Reservation applied last so it wins over a same-edge write
      if (rs && addr_t'(i) == sel_r) pend_d[i] = 1'b1;
      if (ok(sel_a) && addr_t'(i) == sel_a) begin
        a_d  = reg_q[i];
        pa_d = pend_q[i];
      end
      if (ok(sel_b) && addr_t'(i) == sel_b) begin
        b_d  = reg_q[i];
        pb_d = pend_q[i];
      end
    end
    if (we && sel_e == sel_a) begin
      a_d  = e;
      pa_d = 1'b0;
    end
    if (we && sel_e == sel_b) begin
      b_d  = e;
      pb_d = 1'b0;
    end
    inc   = rs && !pr;
    dec   = we && pe && !(rs && sel_r == sel_e);
    cnt_d = cnt_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
  end

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      reg_q  <= '{default: '0};
      pend_q <= '0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      pa_q   <= 1'b0;
      pb_q   <= 1'b0;
    end else begin
      reg_q  <= reg_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      if (hab_leitura) begin
        a_q  <= a_d;
        b_q  <= b_d;
        pa_q <= pa_d;
        pb_q <= pb_d;
      end
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign pend_a      = pa_q;
  assign pend_b      = pb_q;
  assign n_pendentes = cnt_q;

endmodule

// File: doc/banco_registro_param.md
# banco_registro_param

Parametrised register bank for the processor datapath: one write port, two registered read ports with write-first bypass, and a per-register pending (scoreboard) bit so the control unit can stall on registers awaiting a result. Unlike the earlier bank, reads and writes proceed in the same cycle. Width, address size and depth are parameters. Sits between the control unit/ULA write-back and the operand latches feeding the ULA.

## Interface

- BITS_PALAVRA, 16, data word width
- END_REGISTROS, 3, register address width
- NUM_REGISTROS, 2**END_REGISTROS, number of registers; must be ≤ 2**END_REGISTROS and ≥ 2
- clock  input  1  clock; all state updates on the falling edge
- reset  input  1  asynchronous, active-low reset
- hab_escrita  input  1  write enable
- sel_e  input  END_REGISTROS  write address
- e  input  BITS_PALAVRA  write data
- hab_leitura  input  1  read enable; when low, a/b/pend_a/pend_b hold
- sel_a  input  END_REGISTROS  read address, port A
- sel_b  input  END_REGISTROS  read address, port B
- reserva  input  1  mark register sel_r as pending
- sel_r  input  END_REGISTROS  reservation address
- a  output  BITS_PALAVRA  registered read data, port A
- b  output  BITS_PALAVRA  registered read data, port B
- pend_a  output  1  registered pending flag of sel_a
- pend_b  output  1  registered pending flag of sel_b
- n_pendentes  output  END_REGISTROS+1  count of registers currently pending

## Operation

- State: registro[NUM_REGISTROS], pendente[NUM_REGISTROS], read registers, counter.
- Write, falling edge with hab_escrita=1: registro[sel_e] <= e; pendente[sel_e] <= 0.
- Reserve, falling edge with reserva=1: pendente[sel_r] <= 1.
- Reserve and write to the same address on the same edge: the reservation wins. The data is written, but pendente stays/goes 1.
- Read, falling edge with hab_leitura=1:
  - a <= (hab_escrita && sel_e==sel_a) ? e : registro[sel_a]; b likewise. This is the write-first bypass.
  - pend_a <= pendente[sel_a] && !(hab_escrita && sel_e==sel_a); pend_b likewise.
  - A reservation on the same edge is not reflected in pend_a/pend_b until the next read.
- Addresses ≥ NUM_REGISTROS:
  - Writes and reservations are ignored.
  - Reads return 0 with pend 0.
- n_pendentes equals the population count of pendente after every edge. It is updated incrementally:
  - +1 on a reservation of a non-pending register.
  - −1 on a write clearing a pending register (different address from the reservation).
  - Both events on different addresses: net 0.
  - Reserving an already-pending register: no change.
- Reset low, asynchronous: all registro, pendente, a, b, pend_a, pend_b and n_pendentes go to 0 immediately, and they stay 0 while reset is low. On reset release, the first falling edge operates normally.

## Timing

- Write-to-read latency: a read issued on the same edge as the write returns the new data (bypass). A read on any later edge returns the stored value.
- Read latency: a/b are valid after the falling edge on which hab_leitura was high, and held until the next enabled read.
- Reservation visible on pend_x from the second read edge (the first read edge after the reserving edge).
- No combinational path from inputs to outputs; every output is a flop.

## Configuration

- REG_ZERO_EN defined: register 0 is hardwired to zero.
  - Writes and reservations to address 0 are ignored.
  - Reads of address 0 return 0 with pend 0, including the bypass case.
  - n_pendentes never counts register 0.
- REG_ZERO_EN undefined: register 0 is an ordinary register.

## Test plan

- Reset low mid-operation after writing 16'hBEEF to r3 and reserving r5:
  - a, b, pend_a, pend_b and n_pendentes are 0 immediately.
  - After release, reading r3 returns 0.
- Same edge: write r2=16'h1234 and read sel_a=2, sel_b=2 → a=b=16'h1234. Next edge, write r2=16'h0001 with hab_leitura=0 → a still 16'h1234.
- Reserve r4:
  - Next edge, read sel_a=4 → pend_a=1, n_pendentes=1.
  - Write r4=16'h00FF together with read sel_a=4 → a=16'h00FF, pend_a=0, n_pendentes=0.
- Same edge: reserve r6 and write r6=16'hA5A5 → pendente[6]=1, n_pendentes=1. Same edge: reserve r1 and write clears r6 → n_pendentes stays 1.
- Reserve all registers, then re-reserve r0 → n_pendentes=NUM_REGISTROS with no overflow. Clear all by writes → 0.
- With REG_ZERO_EN: write r0=16'hFFFF, reserve r0, read sel_a=0 → a=0, pend_a=0, n_pendentes=0. Without it, the same stimulus gives a=16'hFFFF, and the next read gives pend_a=1.
